// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - segmented carry-pipelined adder/subtractor with valid/ready handshake
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  // Subtraction is a + ~b + 1, so the conditioned operand and carry-in travel with the beat.
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] s_q;
    logic             rdy;

    logic             v_in;
    logic             c_in;
    logic [SEG-1:0]   a_sl;
    logic [SEG-1:0]   b_sl;
    logic [WIDTH-1:0] s_in;
    logic [SEG:0]     add;
    logic [WIDTH-1:0] s_nxt;

    if (k == 0) begin : g_src
      assign v_in = in_valid;
      assign a_sl = a[SEG-1:0];
      assign b_sl = b_eff[SEG-1:0];
      assign c_in = c0;
      assign s_in = '0;
    end else begin : g_src
      assign v_in = g_stage[k-1].v_q;
      assign a_sl = g_stage[k-1].g_fwd.a_q[k*SEG +: SEG];
      assign b_sl = g_stage[k-1].g_fwd.b_q[k*SEG +: SEG];
      assign c_in = g_stage[k-1].c_q;
      assign s_in = g_stage[k-1].s_q;
    end

    // A stage may advance when it is empty or the stage after it is advancing (bubbles collapse).
    if (k == STAGES - 1) begin : g_rdy
      assign rdy = !v_q || out_ready;
    end else begin : g_rdy
      assign rdy = !v_q || g_stage[k+1].rdy;
    end

    assign add = {1'b0, a_sl} + {1'b0, b_sl} + {{SEG{1'b0}}, c_in};

    // Drop this stage's sum slice into the partial sum carried by the beat.
    always_comb begin
      s_nxt = s_in;
      s_nxt[k*SEG +: SEG] = add[SEG-1:0];
    end

    // Stage register: valid bit, registered carry and accumulated partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (rdy) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= add[SEG];
          s_q <= s_nxt;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      // Signed overflow: operands agree in sign but the result's sign differs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (rdy && v_in) begin
          ovf_q <= (a_sl[SEG-1] == b_sl[SEG-1]) && (add[SEG-1] != a_sl[SEG-1]);
        end
      end
    end else begin : g_fwd
      localparam int LO = (k + 1) * SEG;
      logic [WIDTH-1:LO] a_q;
      logic [WIDTH-1:LO] b_q;
      logic [WIDTH-1:LO] a_src;
      logic [WIDTH-1:LO] b_src;

      if (k == 0) begin : g_op
        assign a_src = a[WIDTH-1:LO];
        assign b_src = b_eff[WIDTH-1:LO];
      end else begin : g_op
        assign a_src = g_stage[k-1].g_fwd.a_q[WIDTH-1:LO];
        assign b_src = g_stage[k-1].g_fwd.b_q[WIDTH-1:LO];
      end

      // Only the operand slices later stages still need are carried forward.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy && v_in) begin
          a_q <= a_src;
          b_q <= b_src;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub (SEG=4 and SEG=16 builds)
module tb_pipelined_addsub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;
  logic         in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
  logic [W-1:0] a1, b1, sum1;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_addsub #(.WIDTH(W), .SEG(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pops0 = 0;
  bit   lat0 = 1'b0;
  bit   lat1 = 1'b0;

  logic [15:0] da [8] = '{16'h0003, 16'hFFFF, 16'h7FFF, 16'h000A, 16'h0005, 16'h8000, 16'hFFFF, 16'h0000};
  logic [15:0] db [8] = '{16'h0005, 16'h0001, 16'h0001, 16'h0005, 16'h000A, 16'h0001, 16'hFFFF, 16'h0000};
  logic        dc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        ds [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic s, input int acc);
    exp_t e;
    int ux, uy, sx, sy, ur, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      ur = ux - uy;
      sr = sx - sy;
      e.cout = (ux >= uy);
    end else begin
      ur = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      e.cout = (ur > 65535);
    end
    e.sum = ur[15:0];
    e.ovf = (sr > 32767) || (sr < -32768);
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(output bit ok0, output bit ok1);
    exp_t e;
    @(negedge clk);
    ok0 = in_valid && in_ready;
    ok1 = in_valid1 && in_ready1;
    if (out_valid) begin
      chk("spurious0", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e = q0[0];
        chk("sum0", 32'(sum), 32'(e.sum));
        chk("cout0", 32'(cout), 32'(e.cout));
        chk("ovf0", 32'(ovf), 32'(e.ovf));
        if (out_ready) begin
          void'(q0.pop_front());
          pops0++;
          if (lat0) chk("latency0", cyc - e.acc, 32'd4);
        end
      end
    end
    if (out_valid1) begin
      chk("spurious1", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1[0];
        chk("sum1", 32'(sum1), 32'(e.sum));
        chk("cout1", 32'(cout1), 32'(e.cout));
        chk("ovf1", 32'(ovf1), 32'(e.ovf));
        if (out_ready1) begin
          void'(q1.pop_front());
          if (lat1) chk("latency1", cyc - e.acc, 32'd1);
        end
      end
    end
    if (ok0) q0.push_back(model(a, b, cin, sub, cyc));
    if (ok1) q1.push_back(model(a1, b1, cin1, sub1, cyc));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send0(input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input logic s, output int n);
    bit ok0, ok1;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    n = 0;
    ok0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(ok0, ok1);
      n++;
      if (ok0) break;
    end
    chk("accept0", 32'(ok0), 32'd1);
  endtask

  task automatic drain();
    bit ok0, ok1;
    for (int i = 0; i < 60; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick(ok0, ok1);
    end
    chk("drain", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit ok0, ok1;
    int n, p, nb;
    bit pend;

    in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
    in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; out_ready1 = 1;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lat0 = 1'b1;
    lat1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send0(da[i], db[i], dc[i], ds[i], n);
      in_valid = 1'b0;
      drain();
    end

    for (int i = 0; i < 150; i++) begin
      send0(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), n);
      if (i > 0) chk("throughput0", n, 32'd1);
    end
    in_valid = 1'b0;
    drain();

    lat0 = 1'b0;
    p = pops0;
    nb = 1;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c < 3) || (c >= 10);
      in_valid = (nb <= 6);
      a = 16'(nb); b = 16'(nb); cin = 0; sub = 0;
      tick(ok0, ok1);
      if (ok0) nb++;
      if (c >= 3 && c < 9) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_sum_hold", 32'(sum), 32'h2);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("bp_count", pops0 - p, 32'd6);

    pend = 1'b0;
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
      tick(ok0, ok1);
      pend = in_valid && !ok0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    lat0 = 1'b1;
    for (int i = 1; i <= 3; i++) send0(16'(i), 16'(i), 1'b0, 1'b0, n);
    in_valid = 1'b0;
    tick(ok0, ok1);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_sum", 32'(sum), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      tick(ok0, ok1);
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    send0(16'h0001, 16'h0001, 1'b0, 1'b0, n);
    in_valid = 1'b0;
    drain();

    a1 = 16'h1234; b1 = 16'h1111; cin1 = 1'b1; sub1 = 1'b0; in_valid1 = 1'b1;
    chk("seg16_in_ready", 32'(in_ready1), 32'd1);
    tick(ok0, ok1);
    chk("seg16_accept", 32'(ok1), 32'd1);
    in_valid1 = 1'b0;
    drain();
    for (int i = 0; i < 30; i++) begin
      a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom);
      in_valid1 = 1'b1;
      chk("seg16_stream_ready", 32'(in_ready1), 32'd1);
      tick(ok0, ok1);
    end
    in_valid1 = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
